roulette_spin_ctrl: RTL
=======================

// Module: roulette_spin_ctrl
// PURPOSE
//   Generates the wheel position for the roulette game. Debounces the SPIN button and
//   steps a slot counter with a slowing step rate until it stops. Publishes the final
//   slot as a one-cycle result strobe. Sits directly upstream of the seven-segment
//   decoder and drives its 4-bit count input.
// PARAMETERS
//   NUM_SLOTS        10    slots on the wheel; count range 0..NUM_SLOTS-1
//   DEBOUNCE_CYCLES  16    stable cycles before debounced button changes (board: 1_000_000)
//   START_DIV        4     cycles per step at spin start
//   DIV_STEP         4     cycles added to the step period after every step
//   STOP_DIV         32    spin ends once the step period reaches >= this value
//   DIV_W            16    width of period/tick counters; STOP_DIV+DIV_STEP+7 < 2**DIV_W
//   JITTER_EN        1     1: add lfsr[2:0] to START_DIV at spin start; 0: deterministic
// PORTS
//   clk           in   1  system clock
//   reset         in   1  synchronous, active-high reset
//   spin_btn      in   1  raw asynchronous push-button, active-high
//   count         out  4  current wheel slot, 0..NUM_SLOTS-1; drives the display decoder
//   spinning      out  1  high while in SPIN state
//   result_valid  out  1  one-cycle pulse when the wheel stops
//   result        out  4  slot at the last stop; held until the next stop
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-high. Reset values: count=0,
//     spinning=0, result_valid=0, result=0, state=IDLE, sync/debounce regs=0, lfsr=8'hA5.
//   - Input path:
//     - 2-FF synchronizer, then debouncer.
//     - Debounced level changes only after the synced input differs from it for
//       DEBOUNCE_CYCLES consecutive cycles; any glitch restarts the count.
//     - Rising-edge detect on the debounced level gives spin_req (1 cycle).
//   - lfsr: 8-bit Fibonacci LFSR, taps 8,6,5,4. Free-runs every cycle, never all-zero.
//   - FSM IDLE -> SPIN -> DONE -> IDLE:
//     - IDLE: on spin_req, load div = START_DIV (+lfsr[2:0] if JITTER_EN) and tick = 0;
//       go to SPIN. spinning rises in the next cycle.
//     - SPIN: tick increments every cycle. When tick == div-1: set tick = 0,
//       count = (count==NUM_SLOTS-1) ? 0 : count+1, and div = div + DIV_STEP.
//       If the new div >= STOP_DIV, go to DONE in the same edge.
//     - DONE (1 cycle): result = count, result_valid = 1, spinning = 0, go to IDLE.
//   - spin_req in SPIN or DONE is ignored (no restart, no queueing).
//   - count never leaves 0..NUM_SLOTS-1. It holds its value in IDLE, so the display
//     shows the last result.
//   - Latency: spinning rises DEBOUNCE_CYCLES+3 cycles after a clean spin_btn rise.
//   - Reset asserted mid-spin: all state returns to reset values on that edge.
//     No result_valid is produced for the aborted spin.
//   - Button held through the whole spin: no second spin. A release/press cycle is
//     required, because spin_req is edge-based.
// STRUCTURE
//   - roulette_defs.vh (shared include): FSM state encodings (IDLE=2'd0, SPIN=2'd1,
//     DONE=2'd2) and the default NUM_SLOTS. The display decoder uses the same slot count.
//   - Sub-module button_debouncer (params DEBOUNCE_CYCLES). It contains the synchronizer,
//     the stability counter and the rising-edge pulse output. It is reused for
//     future buttons.
//   - The remainder (lfsr, FSM, tick/div counters, slot counter) stays in this module.
// TESTING (JITTER_EN=0, defaults otherwise)
//   1. Reset, then a clean press held 40 cycles.
//      -> spinning at cycle 19 after press; 7 steps (div 4..28) over 112 cycles;
//         result_valid pulse with result=7, count=7.
//   2. Second press after test 1 -> count wraps 9->0 mid-spin; result = (7+7)%10 = 4.
//   3. spin_btn glitches high for 10 cycles (< DEBOUNCE_CYCLES) -> no spinning, count unchanged.
//   4. Second press while spinning -> ignored; exactly one result_valid; result as in test 1.
//   5. reset pulsed mid-spin at step 3 -> count=0, spinning=0, no result_valid; next press behaves as test 1.
//   6. Button held for 500 cycles -> exactly one spin and one result_valid.

Source files
------------

// File: rtl/roulette_spin_ctrl_pkg.sv
// Shared definitions for the roulette wheel controller: FSM states, default
// slot count and the LFSR step function.
package roulette_spin_ctrl_pkg;

  localparam int NUM_SLOTS_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SPIN = 2'd1,
    DONE = 2'd2
  } state_e;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4; a non-zero seed never reaches all-zero.
  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/roulette_spin_ctrl_button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, stability-count debouncer and a
// one-cycle pulse on every rising edge of the debounced level.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] stableCnt_q, stableCnt_d;

  // Any cycle where the synced input agrees with the level restarts the count.
  always_comb begin
    level_d     = level_q;
    rise_d      = 1'b0;
    stableCnt_d = '0;
    if (sync2_q != level_q) begin
      if (stableCnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        stableCnt_d = stableCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      level_q     <= 1'b0;
      rise_q      <= 1'b0;
      stableCnt_q <= '0;
    end else begin
      sync1_q     <= btn_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      rise_q      <= rise_d;
      stableCnt_q <= stableCnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/roulette_spin_ctrl.sv
// Roulette wheel position generator: debounced SPIN button starts a slot counter
// whose step period grows after every step until the wheel stops.
module roulette_spin_ctrl
  import roulette_spin_ctrl_pkg::*;
#(
  parameter int NUM_SLOTS       = NUM_SLOTS_DEF,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int START_DIV       = 4,
  parameter int DIV_STEP        = 4,
  parameter int STOP_DIV        = 32,
  parameter int DIV_W           = 16,
  parameter int JITTER_EN       = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spin_btn,
  output logic [3:0] count,
  output logic       spinning,
  output logic       result_valid,
  output logic [3:0] result
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] tick_q, tick_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       count_q, count_d;
  logic [3:0]       result_q, result_d;
  logic [7:0]       lfsr_q;
  logic             spinReq;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_spinBtn (
    .clk   (clk),
    .reset (reset),
    .btn_i (spin_btn),
    .rise_o(spinReq)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      div_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      lfsr_q   <= 8'hA5;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      div_q    <= div_d;
      count_q  <= count_d;
      result_q <= result_d;
      lfsr_q   <= lfsrNext(lfsr_q);
    end
  end

  // The result is captured on the stopping edge so it is already valid in DONE.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    div_d    = div_q;
    count_d  = count_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (spinReq) begin
          div_d   = DIV_W'(START_DIV);
          if (JITTER_EN != 0) begin
            div_d = DIV_W'(START_DIV) + DIV_W'(lfsr_q[2:0]);
          end
          tick_d  = '0;
          state_d = SPIN;
        end
      end
      SPIN: begin
        if (tick_q == div_q - DIV_W'(1)) begin
          tick_d  = '0;
          count_d = (count_q == 4'(NUM_SLOTS - 1)) ? 4'd0 : count_q + 4'd1;
          div_d   = div_q + DIV_W'(DIV_STEP);
          if (div_d >= DIV_W'(STOP_DIV)) begin
            state_d  = DONE;
            result_d = count_d;
          end
        end else begin
          tick_d = tick_q + DIV_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    spinning     = (state_q == SPIN);
    result_valid = (state_q == DONE);
  end

  assign count  = count_q;
  assign result = result_q;

endmodule
